// File: rtl/trap_pkg.sv
// ---------------------------------------------------------------------------
// trap_pkg
//   Shared definitions for the trap sequencer:
//   exception/interrupt cause codes, mstatus bit positions,
//   privilege encodings and the trap FSM state encoding.
//   Optional feature macro used by the consumers of this package:
//   TRAP_CTRL_IRQ_EN.
// ---------------------------------------------------------------------------
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RETURN = 2'd3
    } trap_state_e;

    // Synchronous exception causes
    localparam logic [3:0] CAUSE_MISALIGN_IF = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;
    localparam logic [3:0] CAUSE_MISALIGN_LD = 4'd4;
    localparam logic [3:0] CAUSE_ECALL_U     = 4'd8;
    localparam logic [3:0] CAUSE_ECALL_S     = 4'd9;
    localparam logic [3:0] CAUSE_ECALL_M     = 4'd11;

    // Interrupt causes (mcause MSB set separately)
    localparam logic [3:0] CAUSE_IRQ_MSI     = 4'd3;
    localparam logic [3:0] CAUSE_IRQ_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_IRQ_MEI     = 4'd11;

    // mstatus fields
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Privilege levels
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/trap_prio_enc.sv
// ---------------------------------------------------------------------------
// trap_prio_enc
//   Combinational priority encoder for trap requests.
//   Order: fetch misalign > illegal/CSR fault > EBREAK > ECALL >
//          load misalign > interrupt (MEI > MSI > MTI).
//   Ports:
//     priv_lvl         current privilege (selects ECALL cause)
//     exc_* / is_*     synchronous exception requests
//     pc_cur, pc_target, instr_bits, csr_exc_val, ld_addr  mtval sources
//     irq_req          {MEI,MTI,MSI} already masked by enables/global gate
//     valid            some trap requested
//     intr             selected trap is an interrupt
//     cause            4-bit cause code
//     mtval            trap value for the selected request
//   irq_req is tied to zero by the parent unless TRAP_CTRL_IRQ_EN is defined.
// ---------------------------------------------------------------------------
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      priv_lvl,
    input  logic [XLEN-1:0] pc_cur,
    input  logic [31:0]     instr_bits,
    input  logic            exc_misalign_if,
    input  logic [XLEN-1:0] pc_target,
    input  logic            exc_illegal,
    input  logic            csr_exc_en,
    input  logic [XLEN-1:0] csr_exc_val,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            exc_misalign_ld,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [2:0]      irq_req,
    output logic            valid,
    output logic            intr,
    output logic [3:0]      cause,
    output logic [XLEN-1:0] mtval
);

    always_comb begin
        valid = 1'b1;
        intr  = 1'b0;
        cause = 4'd0;
        mtval = '0;
        if (exc_misalign_if) begin
            cause = CAUSE_MISALIGN_IF;
            mtval = pc_target;
        end else if (exc_illegal || csr_exc_en) begin
            cause = CAUSE_ILLEGAL;
            // A CSR fault reports the CSR address rather than the opcode
            mtval = csr_exc_en ? csr_exc_val : {{(XLEN-32){1'b0}}, instr_bits};
        end else if (is_ebreak) begin
            cause = CAUSE_BREAKPOINT;
            mtval = pc_cur;
        end else if (is_ecall) begin
            case (priv_lvl)
                PRIV_U:  cause = CAUSE_ECALL_U;
                PRIV_S:  cause = CAUSE_ECALL_S;
                default: cause = CAUSE_ECALL_M;
            endcase
        end else if (exc_misalign_ld) begin
            cause = CAUSE_MISALIGN_LD;
            mtval = ld_addr;
        end else if (irq_req[2]) begin
            intr  = 1'b1;
            cause = CAUSE_IRQ_MEI;
        end else if (irq_req[0]) begin
            intr  = 1'b1;
            cause = CAUSE_IRQ_MSI;
        end else if (irq_req[1]) begin
            intr  = 1'b1;
            cause = CAUSE_IRQ_MTI;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//   Trap sequencer upstream of csr_machine. Arbitrates synchronous
//   exceptions, optional interrupts and MRET; produces trap_taken/trap_done
//   with the next mepc/mcause/mtval/mstatus values, owns the privilege
//   level, stalls/flushes the pipeline and issues the PC redirect.
//   Sequences: IDLE -> ENTER -> VECTOR -> IDLE (trap)
//              IDLE -> RETURN -> IDLE          (MRET)
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     pc_cur .. ld_addr        request inputs and their mtval sources
//     is_mret                  MRET request
//     irq_pending, irq_enable  {MEI,MTI,MSI}; only used with TRAP_CTRL_IRQ_EN
//     mstatus_current, mtvec_trap, mepc_cur, mcause_cur, mtval_cur  CSR state
//     trap_taken, trap_done    one-cycle commit pulses
//     mepc/mcause/mtval/mstatus_next  valid with either commit pulse
//     priv_lvl                 current privilege
//     stall, flush             pipeline hold / kill
//     redirect_valid, redirect_pc  fetch redirect
//   Optional feature macro: TRAP_CTRL_IRQ_EN (interrupts + vectored mtvec).
// ---------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    input  logic [31:0]     instr_bits,
    input  logic            exc_misalign_if,
    input  logic [XLEN-1:0] pc_target,
    input  logic            exc_illegal,
    input  logic            csr_exc_en,
    input  logic [XLEN-1:0] csr_exc_val,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            exc_misalign_ld,
    input  logic [XLEN-1:0] ld_addr,
    input  logic            is_mret,
    input  logic [2:0]      irq_pending,
    input  logic [2:0]      irq_enable,
    input  logic [XLEN-1:0] mstatus_current,
    input  logic [XLEN-1:0] mtvec_trap,
    input  logic [XLEN-1:0] mepc_cur,
    input  logic [XLEN-1:0] mcause_cur,
    input  logic [XLEN-1:0] mtval_cur,
    output logic            trap_taken,
    output logic            trap_done,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mtval_next,
    output logic [XLEN-1:0] mstatus_next,
    output logic [1:0]      priv_lvl,
    output logic            stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_e     state, state_nxt;
    logic [2:0]      irq_req;
    logic            enc_valid, enc_intr;
    logic [3:0]      enc_cause;
    logic [XLEN-1:0] enc_mtval;
    logic            intr_p1;
    logic [3:0]      cause_p1;
    logic [XLEN-1:0] mtval_p1, mepc_p1, vector_pc;

    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms,
                                                         input logic [1:0]      pl);
        logic [XLEN-1:0] r;
        r                               = ms;
        r[MSTATUS_MPIE]                 = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]                  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = pl;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r                               = ms;
        r[MSTATUS_MIE]                  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                 = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        return r;
    endfunction

`ifdef TRAP_CTRL_IRQ_EN
    // Interrupts are globally enabled by MIE in M-mode, always below M-mode
    logic irq_glb;
    assign irq_glb = mstatus_current[MSTATUS_MIE] | (priv_lvl != PRIV_M);
    assign irq_req = irq_pending & irq_enable & {3{irq_glb}};

    always_comb begin
        vector_pc = {mtvec_trap[XLEN-1:2], 2'b00};
        if (intr_p1 && (mtvec_trap[1:0] == 2'b01))
            vector_pc = vector_pc + {{(XLEN-6){1'b0}}, cause_p1, 2'b00};
    end

    logic unused_ok;
    assign unused_ok = pc_cur[0];
`else
    assign irq_req   = 3'b000;
    assign vector_pc = {mtvec_trap[XLEN-1:2], 2'b00};

    logic unused_ok;
    assign unused_ok = ^{irq_pending, irq_enable, mtvec_trap[1:0], pc_cur[0], intr_p1};
`endif

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .priv_lvl        (priv_lvl),
        .pc_cur          (pc_cur),
        .instr_bits      (instr_bits),
        .exc_misalign_if (exc_misalign_if),
        .pc_target       (pc_target),
        .exc_illegal     (exc_illegal),
        .csr_exc_en      (csr_exc_en),
        .csr_exc_val     (csr_exc_val),
        .is_ecall        (is_ecall),
        .is_ebreak       (is_ebreak),
        .exc_misalign_ld (exc_misalign_ld),
        .ld_addr         (ld_addr),
        .irq_req         (irq_req),
        .valid           (enc_valid),
        .intr            (enc_intr),
        .cause           (enc_cause),
        .mtval           (enc_mtval)
    );

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---- next-state logic: requests only considered in IDLE ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enc_valid)    state_nxt = ST_ENTER;
                else if (is_mret) state_nxt = ST_RETURN;
            end
            ST_ENTER:  state_nxt = ST_VECTOR;
            ST_VECTOR: state_nxt = ST_IDLE;
            ST_RETURN: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---- privilege register ----
    always_ff @(posedge clk) begin
        if (rst)                    priv_lvl <= RESET_PRIV;
        else if (state == ST_ENTER)  priv_lvl <= PRIV_M;
        else if (state == ST_RETURN) priv_lvl <= mstatus_current[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    end

    // ---- p1: trap request captured on the IDLE sample edge ----
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            intr_p1  <= enc_intr;
            cause_p1 <= enc_cause;
            mtval_p1 <= enc_mtval;
            mepc_p1  <= {pc_cur[XLEN-1:1], 1'b0};
        end
    end

    // ---- outputs: reset masks everything so an aborted sequence never commits ----
    always_comb begin
        trap_taken     = 1'b0;
        trap_done      = 1'b0;
        mepc_next      = '0;
        mcause_next    = '0;
        mtval_next     = '0;
        mstatus_next   = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!rst) begin
            case (state)
                ST_IDLE: stall = enc_valid | is_mret;
                ST_ENTER: begin
                    stall        = 1'b1;
                    trap_taken   = 1'b1;
                    mepc_next    = mepc_p1;
                    mcause_next  = {intr_p1, {(XLEN-5){1'b0}}, cause_p1};
                    mtval_next   = mtval_p1;
                    mstatus_next = mstatus_on_trap(mstatus_current, priv_lvl);
                end
                ST_VECTOR: begin
                    stall          = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = vector_pc;
                end
                ST_RETURN: begin
                    stall          = 1'b1;
                    trap_done      = 1'b1;
                    mepc_next      = mepc_cur;
                    mcause_next    = mcause_cur;
                    mtval_next     = mtval_cur;
                    mstatus_next   = mstatus_on_mret(mstatus_current);
                    redirect_valid = 1'b1;
                    redirect_pc    = {mepc_cur[XLEN-1:1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign flush = stall;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//   Directed self-checking bench for trap_ctrl. Inputs change 1 time unit
//   after the rising edge; outputs are checked 1 unit after that.
//   Interrupt vectors are included only when TRAP_CTRL_IRQ_EN is defined.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_cur, pc_target, csr_exc_val, ld_addr;
    logic [31:0] instr_bits;
    logic        exc_misalign_if, exc_illegal, csr_exc_en, is_ecall, is_ebreak;
    logic        exc_misalign_ld, is_mret;
    logic [2:0]  irq_pending, irq_enable;
    logic [63:0] mstatus_current, mtvec_trap, mepc_cur, mcause_cur, mtval_cur;
    logic        trap_taken, trap_done;
    logic [63:0] mepc_next, mcause_next, mtval_next, mstatus_next;
    logic [1:0]  priv_lvl;
    logic        stall, flush, redirect_valid;
    logic [63:0] redirect_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(64), .RESET_PRIV(2'b11)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_cur          (pc_cur),
        .instr_bits      (instr_bits),
        .exc_misalign_if (exc_misalign_if),
        .pc_target       (pc_target),
        .exc_illegal     (exc_illegal),
        .csr_exc_en      (csr_exc_en),
        .csr_exc_val     (csr_exc_val),
        .is_ecall        (is_ecall),
        .is_ebreak       (is_ebreak),
        .exc_misalign_ld (exc_misalign_ld),
        .ld_addr         (ld_addr),
        .is_mret         (is_mret),
        .irq_pending     (irq_pending),
        .irq_enable      (irq_enable),
        .mstatus_current (mstatus_current),
        .mtvec_trap      (mtvec_trap),
        .mepc_cur        (mepc_cur),
        .mcause_cur      (mcause_cur),
        .mtval_cur       (mtval_cur),
        .trap_taken      (trap_taken),
        .trap_done       (trap_done),
        .mepc_next       (mepc_next),
        .mcause_next     (mcause_next),
        .mtval_next      (mtval_next),
        .mstatus_next    (mstatus_next),
        .priv_lvl        (priv_lvl),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        exc_misalign_if = 1'b0;
        exc_illegal     = 1'b0;
        csr_exc_en      = 1'b0;
        is_ecall        = 1'b0;
        is_ebreak       = 1'b0;
        exc_misalign_ld = 1'b0;
        is_mret         = 1'b0;
        irq_pending     = 3'b000;
    endtask

    // Request already driven in IDLE; walks ENTER, VECTOR and back to IDLE.
    task automatic run_trap(input string tag, input logic [63:0] e_cause, input logic [63:0] e_mtval,
                            input logic [63:0] e_mepc, input logic [63:0] e_mst,
                            input logic [63:0] e_redir);
        #1;
        chk({tag, ".stall_req"}, stall, 1);
        tick();
        clear_req();
        #1;
        chk({tag, ".taken"},   trap_taken, 1);
        chk({tag, ".done"},    trap_done, 0);
        chk({tag, ".mcause"},  mcause_next, e_cause);
        chk({tag, ".mtval"},   mtval_next, e_mtval);
        chk({tag, ".mepc"},    mepc_next, e_mepc);
        chk({tag, ".mstatus"}, mstatus_next, e_mst);
        chk({tag, ".rv_enter"}, redirect_valid, 0);
        chk({tag, ".flush"},   flush, 1);
        tick();
        chk({tag, ".rv_vec"},  redirect_valid, 1);
        chk({tag, ".rpc"},     redirect_pc, e_redir);
        chk({tag, ".taken_vec"}, trap_taken, 0);
        chk({tag, ".priv_m"},  priv_lvl, 2'b11);
        tick();
        chk({tag, ".stall_idle"}, stall, 0);
        chk({tag, ".rv_idle"}, redirect_valid, 0);
    endtask

    task automatic run_mret(input string tag, input logic [63:0] mepc, input logic [63:0] mst,
                            input logic [63:0] e_mst, input logic [1:0] e_priv);
        is_mret         = 1'b1;
        mepc_cur        = mepc;
        mstatus_current = mst;
        #1;
        chk({tag, ".stall_req"}, stall, 1);
        tick();
        clear_req();
        #1;
        chk({tag, ".done"},    trap_done, 1);
        chk({tag, ".taken"},   trap_taken, 0);
        chk({tag, ".rv"},      redirect_valid, 1);
        chk({tag, ".rpc"},     redirect_pc, {mepc[63:1], 1'b0});
        chk({tag, ".mstatus"}, mstatus_next, e_mst);
        chk({tag, ".mepc"},    mepc_next, mepc);
        chk({tag, ".mcause"},  mcause_next, mcause_cur);
        tick();
        chk({tag, ".priv"},    priv_lvl, e_priv);
        chk({tag, ".done_off"}, trap_done, 0);
        chk({tag, ".stall_idle"}, stall, 0);
    endtask

    initial begin
        rst             = 1'b1;
        clear_req();
        pc_cur          = 64'h0;
        instr_bits      = 32'h0;
        pc_target       = 64'h0;
        csr_exc_val     = 64'h0;
        ld_addr         = 64'h0;
        irq_enable      = 3'b000;
        mstatus_current = 64'h0;
        mtvec_trap      = 64'h8000;
        mepc_cur        = 64'h0;
        mcause_cur      = 64'h5;
        mtval_cur       = 64'h6;

        // Reset state
        tick();
        tick();
        chk("rst.taken",  trap_taken, 0);
        chk("rst.done",   trap_done, 0);
        chk("rst.stall",  stall, 0);
        chk("rst.flush",  flush, 0);
        chk("rst.rv",     redirect_valid, 0);
        chk("rst.priv",   priv_lvl, 2'b11);
        chk("rst.mcause", mcause_next, 0);
        rst = 1'b0;

        // MRET from M into U (MPP=00, MPIE=1)
        run_mret("mret_to_u", 64'h2000, 64'h80, 64'h88, 2'b00);

        // Illegal instruction in U
        exc_illegal     = 1'b1;
        pc_cur          = 64'h1000;
        instr_bits      = 32'hFFFF_FFFF;
        mstatus_current = 64'h8;
        run_trap("illegal_u", 64'd2, 64'hFFFF_FFFF, 64'h1000, 64'h80, 64'h8000);

        // ECALL from U, then MRET back
        run_mret("mret_u2", 64'h1000, 64'h80, 64'h88, 2'b00);
        is_ecall        = 1'b1;
        pc_cur          = 64'h1000;
        mstatus_current = 64'h80;
        run_trap("ecall_u", 64'd8, 64'h0, 64'h1000, 64'h0, 64'h8000);
        run_mret("mret_1004", 64'h1004, 64'h80, 64'h88, 2'b00);

        // MRET and illegal together: exception wins
        is_mret         = 1'b1;
        exc_illegal     = 1'b1;
        pc_cur          = 64'h1004;
        instr_bits      = 32'h1234_5678;
        mstatus_current = 64'h88;
        run_trap("mret_vs_ill", 64'd2, 64'h1234_5678, 64'h1004, 64'h80, 64'h8000);

        // CSR fault in M; a request raised during ENTER/VECTOR is ignored
        csr_exc_en      = 1'b1;
        csr_exc_val     = 64'h7C0;
        pc_cur          = 64'h5000;
        mstatus_current = 64'h88;
        #1;
        chk("csr.stall_req", stall, 1);
        tick();
        clear_req();
        #1;
        chk("csr.taken",   trap_taken, 1);
        chk("csr.mcause",  mcause_next, 64'd2);
        chk("csr.mtval",   mtval_next, 64'h7C0);
        chk("csr.mstatus", mstatus_next, 64'h1880);
        is_ebreak = 1'b1;
        tick();
        chk("csr.rv",      redirect_valid, 1);
        chk("csr.rpc",     redirect_pc, 64'h8000);
        tick();
        is_ebreak = 1'b0;
        #1;
        chk("csr.ign_taken", trap_taken, 0);
        chk("csr.ign_stall", stall, 0);
        tick();
        chk("csr.ign_taken2", trap_taken, 0);
        chk("csr.ign_rv",     redirect_valid, 0);

        // Fetch misalign beats illegal; mepc LSB cleared
        exc_misalign_if = 1'b1;
        exc_illegal     = 1'b1;
        pc_target       = 64'h1002;
        pc_cur          = 64'h1001;
        mstatus_current = 64'h0;
        run_trap("misalign_if", 64'd0, 64'h1002, 64'h1000, 64'h1800, 64'h8000);

        // ECALL from M beats load misalign
        is_ecall        = 1'b1;
        exc_misalign_ld = 1'b1;
        ld_addr         = 64'h4003;
        pc_cur          = 64'h2000;
        mstatus_current = 64'h2;
        run_trap("ecall_m", 64'd11, 64'h0, 64'h2000, 64'h1802, 64'h8000);

        // Load misalign alone
        exc_misalign_ld = 1'b1;
        ld_addr         = 64'h4003;
        pc_cur          = 64'h2004;
        mstatus_current = 64'h2;
        run_trap("misalign_ld", 64'd4, 64'h4003, 64'h2004, 64'h1802, 64'h8000);

        // Reset during ENTER aborts the trap
        run_mret("mret_u3", 64'h3000, 64'h80, 64'h88, 2'b00);
        is_ebreak       = 1'b1;
        pc_cur          = 64'h3000;
        mstatus_current = 64'h8;
        tick();
        clear_req();
        #1;
        chk("ebrk.taken",  trap_taken, 1);
        chk("ebrk.mcause", mcause_next, 64'd3);
        chk("ebrk.mtval",  mtval_next, 64'h3000);
        chk("ebrk.mst",    mstatus_next, 64'h80);
        rst = 1'b1;
        #1;
        chk("abort.taken", trap_taken, 0);
        chk("abort.stall", stall, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort.rv",     redirect_valid, 0);
        chk("abort.priv",   priv_lvl, 2'b11);
        chk("abort.taken2", trap_taken, 0);
        chk("abort.stall2", stall, 0);
        chk("abort.mcause", mcause_next, 0);
        tick();
        chk("abort.rv2",    redirect_valid, 0);

`ifdef TRAP_CTRL_IRQ_EN
        // Interrupt masked by MIE=0 in M-mode
        irq_pending     = 3'b110;
        irq_enable      = 3'b111;
        mstatus_current = 64'h0;
        #1;
        chk("irq.masked", stall, 0);
        // MEI beats MTI; vectored mtvec
        mstatus_current = 64'h8;
        mtvec_trap      = 64'h8001;
        pc_cur          = 64'h6000;
        run_trap("irq_mei", 64'h8000_0000_0000_000B, 64'h0, 64'h6000, 64'h1880, 64'h802C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
